// File: rtl/mask_pkg.sv
// Shared types and sizing helpers for the chunk mask pipeline.
package mask_pkg;

    typedef enum logic {
        MASK_ZERO = 1'b0,
        MASK_HOLD = 1'b1
    } mask_mode_e;

    function automatic int ceil_division(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    function automatic int nchunk(input int width, input int chunk);
        return ceil_division(width, chunk);
    endfunction

endpackage

// File: rtl/chunk_mask_lane.sv
// One lane: NCHUNK-deep mask shift register, optional hold registers and
// per-slice output gating. Slice k of the data is gated by mask stage k.
module chunk_mask_lane
    import mask_pkg::*;
#(
    parameter int         WIDTH = 8,
    parameter int         CHUNK = 1,
    parameter mask_mode_e MODE  = MASK_ZERO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] in,
    input  logic             in_mask,
    output logic [WIDTH-1:0] out,
    output logic             out_mask
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);

    logic [NCHUNK-1:0] m_q;
    logic [NCHUNK-1:0] m_d;
    logic [NCHUNK:0]   m_shifted;
    logic [WIDTH-1:0]  mask_bits;
    logic [WIDTH-1:0]  h_q;

    // Extra top bit lets NCHUNK=1 share the same shift expression.
    assign m_shifted = {m_q, in_mask};

    always_comb begin
        // NOTE: assign a default first so every path drives m_d and no latch is inferred.
        m_d = m_q;
        if (flush) begin
            m_d = '0;
        end else if (en) begin
            m_d = m_shifted[NCHUNK-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            m_q <= m_d;
        end
    end

    // Fan each slice's mask stage out to its bits; the last slice may be partial.
    for (genvar i = 0; i < WIDTH; i++) begin : g_mask_bit
        assign mask_bits[i] = m_q[i / CHUNK];
    end

    if (MODE == MASK_HOLD) begin : g_hold
        logic [WIDTH-1:0] h_d;

        // Flush leaves the held values untouched, so capture only on a real shift.
        always_comb begin
            h_d = h_q;
            if (en && !flush) begin
                h_d = (in & mask_bits) | (h_q & ~mask_bits);
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                // NOTE: hold registers are reset because out must read 0 while masks are 0.
                h_q <= '0;
            end else begin
                h_q <= h_d;
            end
        end
    end else begin : g_no_hold
        assign h_q = '0;
    end

    assign out      = (in & mask_bits) | (h_q & ~mask_bits);
    assign out_mask = m_q[NCHUNK-1];

endmodule

// File: rtl/chunk_mask_pipe.sv
// Multi-lane chunk mask: one chunk_mask_lane per lane plus a shared
// saturating fill counter that reports when the mask pipeline is primed.
module chunk_mask_pipe
    import mask_pkg::*;
#(
    parameter int         WIDTH = 8,
    parameter int         CHUNK = 1,
    parameter int         LANES = 1,
    parameter mask_mode_e MODE  = MASK_ZERO
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   flush,
    input  logic [LANES*WIDTH-1:0] in,
    input  logic [LANES-1:0]       in_mask,
    output logic [LANES*WIDTH-1:0] out,
    output logic [LANES-1:0]       out_mask,
    output logic                   primed
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int FCW    = $clog2(NCHUNK + 1);
    localparam logic [FCW-1:0] FC_MAX = FCW'(NCHUNK);

    logic [FCW-1:0] fc_q;
    logic [FCW-1:0] fc_d;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        chunk_mask_lane #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .MODE  (MODE)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .flush    (flush),
            .in       (in[l*WIDTH +: WIDTH]),
            .in_mask  (in_mask[l]),
            .out      (out[l*WIDTH +: WIDTH]),
            .out_mask (out_mask[l])
        );
    end

    always_comb begin
        fc_d = fc_q;
        if (flush) begin
            fc_d = '0;
        end else if (en && (fc_q != FC_MAX)) begin
            fc_d = fc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fc_q <= '0;
        end else begin
            fc_q <= fc_d;
        end
    end

    assign primed = (fc_q == FC_MAX);

endmodule

// File: tb/tb_chunk_mask_pipe.sv
// Directed bench: three chunk_mask_pipe configurations sharing clock, reset,
// en and flush, each exercised in turn with hand-computed expectations.
module tb_chunk_mask_pipe;
    import mask_pkg::*;

    logic clk;
    logic rst;
    logic en;
    logic flush;

    // 8-bit lanes, 2-bit slices, 2 lanes, zeroing.
    logic [15:0] in_z;
    logic [1:0]  in_mask_z;
    logic [15:0] out_z;
    logic [1:0]  out_mask_z;
    logic        primed_z;

    // 8-bit lane, 2-bit slices, 1 lane, hold-last.
    logic [7:0]  in_h;
    logic        in_mask_h;
    logic [7:0]  out_h;
    logic        out_mask_h;
    logic        primed_h;

    // 7-bit lane, 3-bit slices (last slice partial), zeroing.
    logic [6:0]  in_p;
    logic        in_mask_p;
    logic [6:0]  out_p;
    logic        out_mask_p;
    logic        primed_p;

    int n_checks = 0;
    int n_fail   = 0;

    chunk_mask_pipe #(.WIDTH(8), .CHUNK(2), .LANES(2), .MODE(MASK_ZERO)) u_zero (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .in(in_z), .in_mask(in_mask_z),
        .out(out_z), .out_mask(out_mask_z), .primed(primed_z)
    );

    chunk_mask_pipe #(.WIDTH(8), .CHUNK(2), .LANES(1), .MODE(MASK_HOLD)) u_hold (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .in(in_h), .in_mask(in_mask_h),
        .out(out_h), .out_mask(out_mask_h), .primed(primed_h)
    );

    chunk_mask_pipe #(.WIDTH(7), .CHUNK(3), .LANES(1), .MODE(MASK_ZERO)) u_part (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .in(in_p), .in_mask(in_mask_p),
        .out(out_p), .out_mask(out_mask_p), .primed(primed_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        en        = 1'b0;
        flush     = 1'b0;
        in_mask_z = '0;
        in_mask_h = 1'b0;
        in_mask_p = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // 1: reset state, checked before any clock edge
        rst       = 1'b0;
        en        = 1'b0;
        flush     = 1'b0;
        in_z      = 16'hFFFF;
        in_mask_z = 2'b11;
        in_h      = 8'hFF;
        in_mask_h = 1'b1;
        in_p      = 7'h7F;
        in_mask_p = 1'b1;
        #2;
        check("rst_out", 32'(out_z), 32'h0);
        check("rst_out_mask", 32'(out_mask_z), 32'h0);
        check("rst_primed", 32'(primed_z), 32'h0);
        check("rst_hold_out", 32'(out_h), 32'h0);

        // 2: single-edge mask pulse walks through lane 0 slices
        do_reset();
        en        = 1'b1;
        in_mask_z = 2'b01;
        step();
        check("zero_e1", 32'(out_z), 32'h0003);
        check("zero_e1_om", 32'(out_mask_z), 32'h0);
        in_mask_z = 2'b00;
        step();
        check("zero_e2", 32'(out_z), 32'h000C);
        step();
        check("zero_e3", 32'(out_z), 32'h0030);
        check("zero_e3_primed", 32'(primed_z), 32'h0);
        step();
        check("zero_e4", 32'(out_z), 32'h00C0);
        check("zero_e4_om", 32'(out_mask_z), 32'h1);
        check("zero_e4_primed", 32'(primed_z), 32'h1);
        step();
        check("zero_e5", 32'(out_z), 32'h0000);
        check("zero_e5_om", 32'(out_mask_z), 32'h0);

        // 3: stall for three cycles after edge 2
        do_reset();
        en        = 1'b1;
        in_mask_z = 2'b01;
        step();
        in_mask_z = 2'b00;
        step();
        check("stall_e2", 32'(out_z), 32'h000C);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold", 32'(out_z), 32'h000C);
        end
        check("stall_primed", 32'(primed_z), 32'h0);
        en = 1'b1;
        step();
        check("stall_e3", 32'(out_z), 32'h0030);
        step();
        check("stall_e4", 32'(out_z), 32'h00C0);

        // 4: primed, flush at edge 6, primed again four enabled edges later
        do_reset();
        en        = 1'b1;
        in_mask_z = 2'b01;
        for (int i = 0; i < 3; i++) step();
        check("prm_e3", 32'(primed_z), 32'h0);
        step();
        check("prm_e4", 32'(primed_z), 32'h1);
        check("prm_e4_out", 32'(out_z), 32'h00FF);
        check("prm_e4_om", 32'(out_mask_z), 32'h1);
        step();
        flush = 1'b1;
        step();
        check("flush_primed", 32'(primed_z), 32'h0);
        check("flush_out", 32'(out_z), 32'h0000);
        check("flush_om", 32'(out_mask_z), 32'h0);
        flush     = 1'b0;
        in_mask_z = 2'b00;
        for (int i = 0; i < 3; i++) step();
        check("reprm_e3", 32'(primed_z), 32'h0);
        check("reprm_out", 32'(out_z), 32'h0000);
        step();
        check("reprm_e4", 32'(primed_z), 32'h1);

        // 5: hold-last mode
        do_reset();
        en        = 1'b1;
        in_h      = 8'hA5;
        in_mask_h = 1'b1;
        step();
        check("hold_e1", 32'(out_h), 32'h01);
        for (int i = 0; i < 3; i++) step();
        check("hold_e4", 32'(out_h), 32'hA5);
        step();
        in_mask_h = 1'b0;
        step();
        in_h = 8'h3C;
        #1;
        check("hold_slice0", 32'(out_h), 32'h3D);
        in_h = 8'hA5;
        for (int i = 0; i < 3; i++) step();
        check("hold_om", 32'(out_mask_h), 32'h0);
        in_h = 8'h3C;
        #1;
        check("hold_steady", 32'(out_h), 32'hA5);

        // Asynchronous reset away from any clock edge clears the held value
        rst = 1'b0;
        #1;
        check("async_hold_out", 32'(out_h), 32'h00);
        check("async_primed", 32'(primed_h), 32'h0);
        rst = 1'b1;

        // 6: partial last slice
        do_reset();
        en        = 1'b1;
        in_p      = 7'h7F;
        in_mask_p = 1'b1;
        step();
        check("part_e1", 32'(out_p), 32'h07);
        in_mask_p = 1'b0;
        step();
        check("part_e2", 32'(out_p), 32'h38);
        step();
        check("part_e3", 32'(out_p), 32'h40);
        check("part_e3_om", 32'(out_mask_p), 32'h1);
        check("part_e3_primed", 32'(primed_p), 32'h1);
        step();
        check("part_e4", 32'(out_p), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chunk_mask_pipe.md
# chunk_mask_pipe

Multi-lane, mode-selectable successor to the single-lane chunk mask. Masks one wide word per lane in CHUNK-bit slices. Each slice is gated by that lane's mask bit delayed by the slice index, so the mask stays aligned with skewed data in the staggered pipelined-math datapaths. Adds:
- a hold-last mode;
- a synchronous flush;
- a per-lane aligned mask output;
- a pipeline-primed indicator.

## Interface
- WIDTH, 8: data bits per lane.
- CHUNK, 1: bits per slice; NCHUNK = ceil_division(WIDTH, CHUNK). The last slice may be partial.
- LANES, 1: independent mask lanes, each with its own mask bit.
- MODE, MASK_ZERO: MASK_ZERO forces masked slices to 0. MASK_HOLD outputs the slice's last unmasked value.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  advance enable; all state holds when low.
- flush  in  1  synchronous clear of mask pipeline and fill counter; takes effect regardless of en.
- in  in  LANES*WIDTH  data; lane l occupies bits [l*WIDTH +: WIDTH].
- in_mask  in  LANES  per-lane mask bit entering the pipeline.
- out  out  LANES*WIDTH  masked data, same lane packing as in.
- out_mask  out  LANES  per-lane mask bit seen by slice NCHUNK-1.
- primed  out  1  high once NCHUNK enabled edges have occurred since reset or flush.

## Operation
- Per lane, an NCHUNK-deep mask shift register m[l][0..NCHUNK-1].
- On an edge with en=1 and flush=0: m[l][0] <= in_mask[l] and m[l][k] <= m[l][k-1].
- Slice k of lane l (bits k*CHUNK up to min((k+1)*CHUNK, WIDTH)-1) is gated by m[l][k].
- MASK_ZERO: out slice = in slice AND m[l][k]. Combinational from in; no data registers.
- MASK_HOLD: per-lane, per-slice hold register h.
  - out slice = m[l][k] ? in slice : h[l][k].
  - On an edge with en=1, h[l][k] <= in slice wherever m[l][k]=1 (pre-edge value).
- out_mask[l] = m[l][NCHUNK-1].
- Fill counter fc, range 0..NCHUNK, saturating.
  - Increments on each en=1, flush=0 edge.
  - primed = (fc == NCHUNK).
- flush=1 at an edge: all m <= 0 and fc <= 0. Hold registers keep their contents. flush takes priority over en.
- Reset (rst low, asynchronous): all m, h and fc cleared immediately.
  - Reset values: out = 0, out_mask = 0, primed = 0.
  - In MASK_HOLD, out = h = 0 while masks are 0.

## Timing
- in_mask[l] applied before edge t reaches slice k after edge t+k. Mask latency for slice k is k+1 enabled edges.
- Data path has zero latency: out depends combinationally on in, m and h. No combinational path from in_mask to out.
- en low: m, h and fc frozen; out still follows in for slices whose m=1.
- flush and en both high: flush wins; no shift occurs.
- Reset released mid-stream: the first enabled edge after release loads m[l][0]; primed needs NCHUNK more enabled edges.
- NCHUNK=1 is legal: out_mask = m[l][0] and primed rises after one enabled edge.

## Structure
- Shared package mask_pkg holds:
  - ceil_division function;
  - mask_mode_e enum {MASK_ZERO, MASK_HOLD};
  - nchunk(WIDTH, CHUNK) helper.
- The top generates one chunk_mask_lane instance per lane, containing:
  - mask shift register;
  - hold registers;
  - slice muxing.
- The top owns the shared fill counter and the primed output.

## Test plan
1. Reset, WIDTH=8, CHUNK=2 (NCHUNK=4), LANES=2, in=all ones, rst low -> out=0, out_mask=0, primed=0, immediately and asynchronously.
2. MASK_ZERO, lane 0: in_mask[0]=1 for one enabled edge, in lane 0 = 0xFF -> lane-0 out = 0x03, 0x0C, 0x30, 0xC0 after edges 1 to 4, then 0x00. out_mask[0]=1 only after edge 4. Lane 1 stays 0.
3. Stall: repeat scenario 2 with en=0 for 3 cycles after edge 2 -> out holds 0x0C for those 3 cycles, then resumes 0x30, 0xC0.
4. primed and flush: primed rises after enabled edge 4. flush at edge 6 -> primed=0, out=0 and out_mask=0 after that edge. primed rises again 4 enabled edges later.
5. MASK_HOLD: mask=1 with in=0xA5 for 5 edges, then mask=0 with in=0x3C -> once slice 0 alone sees m=0, out=0x3D. Final steady out = 0xA5.
6. Partial slice, WIDTH=7, CHUNK=3 (NCHUNK=3), in=0x7F, one-edge mask pulse -> out = 0x07, 0x38, 0x40. No X or out-of-range bits.
